// File: rtl/sys_array_seq_if.sv
// Bundles the job handshake, operand-buffer read port and systolic-array control of sys_array_seq.
// Latency: wiring only. Backpressure: none; the sequencer accepts a start only while ready is high.
// Ports: master = sequencer side (drives ready/buf_rd_*/arr_*/result/done/err),
//        slave  = environment side (drives start/k_len/buf_*_data/arr_calc_done/arr_out_c).
interface sys_array_seq_if #(
   parameter int WIDTH      = 16,
   parameter int ARR_HEIGHT = 4,
   parameter int ARR_WIDTH  = 4,
   parameter int SYS_HEIGHT = 1,
   parameter int SYS_WIDTH  = 1,
   parameter int K_MAX      = 64
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int AW = SYS_HEIGHT * ARR_HEIGHT * WIDTH;
   localparam int BW = SYS_WIDTH * ARR_WIDTH * WIDTH;
   localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;

   logic          start;
   logic [KW-1:0] k_len;
   logic          ready;
   logic          buf_rd_en;
   logic [KW-1:0] buf_rd_addr;
   logic [AW-1:0] buf_a_data;
   logic [BW-1:0] buf_b_data;
   logic          arr_reset;
   logic [AW-1:0] arr_in_a;
   logic [BW-1:0] arr_in_b;
   logic          arr_in_done;
   logic          arr_calc_done;
   logic [CW-1:0] arr_out_c;
   logic [CW-1:0] result;
   logic          done;
   logic          err;

   modport master (
      input  start, k_len, buf_a_data, buf_b_data, arr_calc_done, arr_out_c,
      output ready, buf_rd_en, buf_rd_addr, arr_reset, arr_in_a, arr_in_b,
             arr_in_done, result, done, err
   );

   modport slave (
      output start, k_len, buf_a_data, buf_b_data, arr_calc_done, arr_out_c,
      input  ready, buf_rd_en, buf_rd_addr, arr_reset, arr_in_a, arr_in_b,
             arr_in_done, result, done, err
   );
endinterface

// File: rtl/sys_array_seq.sv
// Sequences one matrix job through a systolic array: reset it, stream k_len operand beats, wait for the result.
// Latency: accept-to-done = 1 (ARST) + k_len (FEED) + 1 (FLUSH) + W (WAIT, up to calc_done or TIMEOUT) + 1 (DONE).
// Backpressure: single job in flight; start is ignored unless ready (IDLE), illegal k_len is rejected with an err pulse.
// Ports: clk, reset (sync, active-high), bus (sys_array_seq_if.master: job handshake, buffer read, array control).
module sys_array_seq #(
   parameter int WIDTH      = 16,
   parameter int ARR_HEIGHT = 4,
   parameter int ARR_WIDTH  = 4,
   parameter int SYS_HEIGHT = 1,
   parameter int SYS_WIDTH  = 1,
   parameter int K_MAX      = 64,
   parameter int TIMEOUT    = 1023
) (
   input logic              clk,
   input logic              reset,
   sys_array_seq_if.master  bus
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int AW = SYS_HEIGHT * ARR_HEIGHT * WIDTH;
   localparam int BW = SYS_WIDTH * ARR_WIDTH * WIDTH;
   localparam int CW = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH * WIDTH;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ARST, FEED, FLUSH, WAIT, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k_q;
   logic [KW-1:0] beat;       // doubles as the buffer read address
   logic          rd_en;
   logic          load_q;     // buffer data is valid this cycle (read issued last cycle)
   logic [TW-1:0] wait_cnt;
   logic          ready_q;
   logic          arr_reset_q;
   logic [AW-1:0] in_a_q;
   logic [BW-1:0] in_b_q;
   logic          in_done_q;
   logic [CW-1:0] result_q;
   logic          done_q;
   logic          err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         k_q         <= '0;
         beat        <= '0;
         rd_en       <= 1'b0;
         load_q      <= 1'b0;
         wait_cnt    <= '0;
         ready_q     <= 1'b1;
         arr_reset_q <= 1'b1;
         in_a_q      <= '0;
         in_b_q      <= '0;
         in_done_q   <= 1'b0;
         result_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         // Operands follow the read by one cycle, independent of state, so the
         // last beat is captured during FLUSH without special casing.
         load_q <= rd_en;
         if (load_q) begin
            in_a_q <= bus.buf_a_data;
            in_b_q <= bus.buf_b_data;
         end

         case (state)
            IDLE: begin
               arr_reset_q <= 1'b0;
               if (bus.start) begin
                  if (bus.k_len != '0 && bus.k_len <= KW'(K_MAX)) begin
                     k_q         <= bus.k_len;
                     beat        <= '0;
                     ready_q     <= 1'b0;
                     arr_reset_q <= 1'b1;
                     state       <= ARST;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ARST: begin
               arr_reset_q <= 1'b0;
               beat        <= '0;
               rd_en       <= 1'b1;
               state       <= FEED;
            end
            FEED: begin
               if (beat == k_q - KW'(1)) begin
                  rd_en <= 1'b0;
                  beat  <= '0;
                  state <= FLUSH;
               end else begin
                  beat <= beat + KW'(1);
               end
            end
            FLUSH: begin
               in_done_q <= 1'b1;
               wait_cnt  <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (bus.arr_calc_done) begin
                  result_q  <= bus.arr_out_c;
                  in_done_q <= 1'b0;
                  done_q    <= 1'b1;
                  state     <= DONE;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  // Give up: result keeps the last good value, err flags the timeout.
                  in_done_q <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready       = ready_q;
   assign bus.buf_rd_en   = rd_en;
   assign bus.buf_rd_addr = beat;
   assign bus.arr_reset   = arr_reset_q;
   assign bus.arr_in_a    = in_a_q;
   assign bus.arr_in_b    = in_b_q;
   assign bus.arr_in_done = in_done_q;
   assign bus.result      = result_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_sys_array_seq.sv
// Directed bench for sys_array_seq with a buffer model and an accumulating stub array.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives the DUT through a sys_array_seq_if instance.
module tb_sys_array_seq;
   localparam int WIDTH = 16;
   localparam int K_MAX = 64;
   localparam int TO    = 15;
   localparam int N     = 4;
   localparam int KW    = $clog2(K_MAX + 1);
   localparam int AW    = N * WIDTH;
   localparam int CW    = N * N * WIDTH;

   // Hand-computed A@B results, element (i,j) at bits [(i*4+j)*16 +: 16].
   localparam logic [CW-1:0] C1 = {16'd36, 16'd34, 16'd32, 16'd30, 16'd32, 16'd30, 16'd28, 16'd26,
                                   16'd28, 16'd26, 16'd24, 16'd22, 16'd24, 16'd22, 16'd20, 16'd18};
   localparam logic [CW-1:0] C2 = {16'd100, 16'd80, 16'd60, 16'd40, 16'd75, 16'd60, 16'd45, 16'd30,
                                   16'd50, 16'd40, 16'd30, 16'd20, 16'd25, 16'd20, 16'd15, 16'd10};
   localparam logic [CW-1:0] C3 = {192'd0, 16'd4, 16'd3, 16'd2, 16'd1};
   localparam logic [CW-1:0] C8 = {16'd208, 16'd176, 16'd144, 16'd112, 16'd156, 16'd132, 16'd108, 16'd84,
                                   16'd104, 16'd88, 16'd72, 16'd56, 16'd52, 16'd44, 16'd36, 16'd28};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sys_array_seq_if #(.WIDTH(WIDTH), .K_MAX(K_MAX)) bus ();

   sys_array_seq #(.WIDTH(WIDTH), .K_MAX(K_MAX), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Buffer contents: set 1 is A=[I|1], B[k][j]=4k+j+1; set 2 is A[i][k]=i+1, B[k][j]=k+j.
   function automatic logic [AW-1:0] fa(input int ds, input int k);
      logic [AW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (ds == 1) v[i*WIDTH +: WIDTH] = (k == i || k == 4) ? 16'd1 : 16'd0;
         else         v[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      return v;
   endfunction

   function automatic logic [AW-1:0] fb(input int ds, input int k);
      logic [AW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
         if (ds == 1) v[j*WIDTH +: WIDTH] = WIDTH'(4 * k + j + 1);
         else         v[j*WIDTH +: WIDTH] = WIDTH'(k + j);
      return v;
   endfunction

   int k_cur = 0, w_cur = 0, ds_cur = 1;
   logic inject = 1'b0;

   // Operand buffer: data valid the cycle after a read, poison otherwise.
   always @(posedge clk) begin
      logic rd;
      int   ad;
      rd = bus.buf_rd_en;
      ad = int'(bus.buf_rd_addr);
      #1;
      if (rd) begin
         bus.buf_a_data = fa(ds_cur, ad);
         bus.buf_b_data = fb(ds_cur, ad);
      end else begin
         bus.buf_a_data = {N{16'hdead}};
         bus.buf_b_data = {N{16'hbeef}};
      end
   end

   // Stub array: after arr_reset falls, beat j is expected on arr_in in stub cycle j+2;
   // accumulates outer products and raises calc_done in the w_cur-th cycle of arr_in_done.
   int cyc = 0, indn = 0, beat_err = 0;
   int acc [N*N];
   logic stub_cd = 1'b0;
   logic [CW-1:0] acc_c = '0;
   always @(negedge clk) begin
      if (bus.arr_reset) begin
         cyc = 0; indn = 0; beat_err = 0; stub_cd = 1'b0;
         for (int e = 0; e < N*N; e++) acc[e] = 0;
      end else begin
         if (cyc >= 2 && cyc - 2 < k_cur) begin
            if (bus.arr_in_a !== fa(ds_cur, cyc - 2) || bus.arr_in_b !== fb(ds_cur, cyc - 2)) beat_err++;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  acc[i*N+j] += int'(bus.arr_in_a[i*WIDTH +: WIDTH]) * int'(bus.arr_in_b[j*WIDTH +: WIDTH]);
         end
         cyc++;
         if (bus.arr_in_done) begin
            indn++;
            stub_cd = (w_cur != 0 && indn == w_cur);
         end else begin
            stub_cd = 1'b0;
         end
      end
      for (int e = 0; e < N*N; e++) acc_c[e*WIDTH +: WIDTH] = WIDTH'(acc[e]);
   end
   assign bus.arr_calc_done = stub_cd | inject;
   assign bus.arr_out_c     = acc_c;

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!bus.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " ready before start"}, CW'(bus.ready), CW'(1));
   endtask

   task automatic run_job(input int k, input int w, input int ds, input int exp_lat,
                          input logic exp_err, input logic [CW-1:0] exp_res,
                          input string nm, input bit hold, input int inj_cyc);
      int lat, reads, aerr, indc;
      bit seen;
      k_cur = k; w_cur = w; ds_cur = ds;
      wait_ready(nm);
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      lat = 0; reads = 0; aerr = 0; indc = 0; seen = 0;
      while (!seen && lat < 300) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            if (!hold) bus.start = 1'b0;
            chk({nm, " arst ready/arr_reset"}, CW'({bus.ready, bus.arr_reset}), CW'(2'b01));
         end
         inject = (lat == inj_cyc);
         if (bus.buf_rd_en) begin
            if (int'(bus.buf_rd_addr) != reads) aerr++;
            reads++;
         end
         if (bus.arr_in_done) indc++;
         if (bus.done) seen = 1;
      end
      inject = 1'b0;
      chk({nm, " done seen"}, CW'(seen), CW'(1));
      chk({nm, " latency"}, CW'(lat), CW'(exp_lat));
      chk({nm, " err"}, CW'(bus.err), CW'(exp_err));
      chk({nm, " reads"}, CW'(reads), CW'(k));
      chk({nm, " addr order"}, CW'(aerr), CW'(0));
      chk({nm, " operand beats"}, CW'(beat_err), CW'(0));
      chk({nm, " in_done cycles"}, CW'(indc), CW'((w == 0) ? TO : w));
      chk({nm, " in_done low in done"}, CW'(bus.arr_in_done), CW'(0));
      chk({nm, " result"}, bus.result, exp_res);
      @(negedge clk);
      chk({nm, " done pulse width"}, CW'({bus.done, bus.ready}), CW'(2'b01));
   endtask

   task automatic reject(input int kv, input string nm);
      bus.start = 1'b1;
      bus.k_len = KW'(kv);
      @(negedge clk);
      chk({nm, " err/done/ready/rd_en"}, CW'({bus.err, bus.done, bus.ready, bus.buf_rd_en}), CW'(4'b1010));
      bus.start = 1'b0;
      @(negedge clk);
      chk({nm, " after err/ready/rd_en"}, CW'({bus.err, bus.ready, bus.buf_rd_en}), CW'(3'b010));
   endtask

   typedef struct {
      int            k;
      int            w;
      int            ds;
      int            lat;
      logic          err;
      logic [CW-1:0] res;
   } vec_t;
   vec_t tbl [6];

   initial begin
      int  n, dn;
      bit  found;

      tbl[0] = '{5,  7, 1, 15, 1'b0, C1};   // nominal job, W=7
      tbl[1] = '{5,  1, 2,  9, 1'b0, C2};   // calc_done in first WAIT cycle
      tbl[2] = '{1,  3, 1,  7, 1'b0, C3};   // minimum k_len
      tbl[3] = '{2,  0, 2, 20, 1'b1, C3};   // timeout: result keeps previous job's value
      tbl[4] = '{64, 2, 1, 69, 1'b0, C1};   // k_len = K_MAX
      tbl[5] = '{8,  2, 2, 13, 1'b0, C8};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.buf_a_data = '0;
      bus.buf_b_data = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", CW'(bus.ready), CW'(1));
      chk("reset arr_reset", CW'(bus.arr_reset), CW'(1));
      chk("reset rd_en/addr", CW'({bus.buf_rd_en, bus.buf_rd_addr}), CW'(0));
      chk("reset arr_in_a", CW'(bus.arr_in_a), CW'(0));
      chk("reset arr_in_b", CW'(bus.arr_in_b), CW'(0));
      chk("reset in_done/done/err", CW'({bus.arr_in_done, bus.done, bus.err}), CW'(0));
      chk("reset result", bus.result, CW'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("post reset arr_reset low", CW'({bus.arr_reset, bus.ready}), CW'(2'b01));

      reject(0, "reject k0");
      reject(K_MAX + 1, "reject kmax+1");

      for (int t = 0; t < 6; t++)
         run_job(tbl[t].k, tbl[t].w, tbl[t].ds, tbl[t].lat, tbl[t].err, tbl[t].res,
                 $sformatf("vec%0d", t), 1'b0, 0);

      // Start held high for a whole job plus an early calc_done during FEED.
      run_job(5, 4, 2, 12, 1'b0, C2, "hold", 1'b1, 3);
      @(negedge clk);
      chk("hold reaccept ready/arr_reset", CW'({bus.ready, bus.arr_reset}), CW'(2'b01));
      bus.start = 1'b0;
      n = 1; dn = 0;
      while (!bus.done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("hold second latency", CW'(n), CW'(12));
      chk("hold second result", bus.result, C2);
      @(negedge clk);
      chk("hold second single done", CW'({bus.done, bus.ready}), CW'(2'b01));

      // Reset during FEED beat 3 of a k_len=8 job.
      k_cur = 8; w_cur = 2; ds_cur = 2;
      wait_ready("abort");
      bus.start = 1'b1;
      bus.k_len = KW'(8);
      n = 0; found = 0;
      while (!found && n < 50) begin
         @(negedge clk);
         n++;
         if (n == 1) bus.start = 1'b0;
         if (bus.buf_rd_en && bus.buf_rd_addr == KW'(3)) found = 1;
      end
      chk("abort reached beat 3", CW'(found), CW'(1));
      reset = 1'b1;
      @(negedge clk);
      chk("abort idle ready/in_done/rd_en/done", CW'({bus.ready, bus.arr_in_done, bus.buf_rd_en, bus.done}), CW'(4'b1000));
      chk("abort result cleared", bus.result, CW'(0));
      reset = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("abort no done pulse", CW'(dn), CW'(0));
      run_job(1, 3, 1, 7, 1'b0, C3, "after abort", 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sys_array_seq.md
SYS_ARRAY_SEQ -- requirements
Module: sys_array_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand element width in bits.
REQ-002 SHALL have parameters ARR_HEIGHT and ARR_WIDTH, default 4 each, PE rows and columns per systolic array.
REQ-003 SHALL have parameters SYS_HEIGHT and SYS_WIDTH, default 1 each, array tiling.
REQ-004 SHALL have parameter K_MAX, default 64, maximum inner dimension; KW = $clog2(K_MAX+1).
REQ-005 SHALL have parameter TIMEOUT, default 1023, maximum cycles spent in WAIT.
REQ-006 SHALL define AW = SYS_HEIGHT*ARR_HEIGHT*WIDTH, BW = SYS_WIDTH*ARR_WIDTH*WIDTH and CW = SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 start  in  1  job request; accepted only when ready=1.
REQ-010 k_len  in  KW  inner dimension of the job, sampled at accept.
REQ-011 ready  out  1  high only in IDLE.
REQ-012 buf_rd_en, buf_rd_addr  out  1, KW  operand buffer read; buf_rd_addr = beat index.
REQ-013 buf_a_data, buf_b_data  in  AW, BW  buffer read data, valid exactly 1 cycle after buf_rd_en.
REQ-014 arr_reset  out  1  drives the array's reset.
REQ-015 arr_in_a, arr_in_b  out  AW, BW  array column and row operands (registered).
REQ-016 arr_in_done  out  1  drives the array's in_done_flag.
REQ-017 arr_calc_done  in  1  the array's calc_done_flag.
REQ-018 arr_out_c  in  CW  array result.
REQ-019 result  out  CW  latched result of the last successful job.
REQ-020 done, err  out  1, 1  one-cycle completion pulse; err is valid only with done, or with a rejected start.

Function
REQ-021 States SHALL be IDLE, ARST, FEED, FLUSH, WAIT and DONE.
REQ-022 Accept SHALL occur when IDLE, start=1 and 1<=k_len<=K_MAX: k_len is latched and the next state is ARST.
REQ-023 When IDLE, start=1 and (k_len==0 or k_len>K_MAX): the block SHALL pulse err=1 with done=0 in the same cycle and remain in IDLE.
REQ-024 ARST SHALL last exactly 1 cycle with arr_reset=1; beat counter cleared; next state FEED.
REQ-025 FEED SHALL assert buf_rd_en=1 for exactly k_len consecutive cycles with buf_rd_addr = 0, 1, …, k_len-1, then go to FLUSH.
REQ-026 The cycle after each read, arr_in_a/arr_in_b SHALL be loaded with buf_a_data/buf_b_data; they SHALL hold their value in every other cycle.
REQ-027 FLUSH SHALL last 1 cycle and load the last beat's data; arr_in_done SHALL rise the following cycle.
REQ-028 In WAIT, arr_in_done SHALL be 1 continuously; arr_reset=0 from FEED through DONE.
REQ-029 In WAIT, when arr_calc_done=1: result <= arr_out_c and the next state is DONE.
REQ-030 In WAIT, if TIMEOUT cycles elapse without arr_calc_done: result is unchanged, an err flag is set, and the next state is DONE.
REQ-031 In DONE, done=1 for 1 cycle, err = timeout flag; arr_in_done returns to 0; next state IDLE.
REQ-032 start while not IDLE SHALL be ignored (no queueing).
REQ-033 arr_calc_done outside WAIT SHALL be ignored.
REQ-034 Accept-to-done latency SHALL be 1 (ARST) + k_len (FEED) + 1 (FLUSH) + W (WAIT cycles up to and including calc_done) + 1 (DONE).
REQ-035 The WAIT counter SHALL saturate and never wrap; the beat counter SHALL be KW bits and never wrap for legal k_len.

Reset
REQ-036 reset=1 SHALL force state IDLE, ready=1, arr_reset=1, and all of the following to 0: buf_rd_en, buf_rd_addr, arr_in_a, arr_in_b, arr_in_done, result, done, err, counters.
REQ-037 Reset in any state SHALL abort the job with no done pulse; reset takes priority over start in the same cycle.
REQ-038 After reset deasserts, arr_reset SHALL fall to 0 on the next edge when IDLE.

Verification
REQ-039 Accept k_len=5 with a stub array asserting calc_done 7 cycles after arr_in_done -> buf_rd_addr 0..4 on consecutive cycles, 5 operand beats, done=1 with err=0, result = arr_out_c, latency = 1+5+1+7+1 = 15 cycles.
REQ-040 start with k_len=0, and separately with k_len=K_MAX+1 -> err pulse with done=0, ready stays 1, no buf_rd_en.
REQ-041 Stub array never asserts calc_done, TIMEOUT=15 -> done=1 and err=1 after 15 WAIT cycles; result keeps its previous value.
REQ-042 Assert reset during FEED beat 3 of k_len=8 -> next cycle IDLE, arr_in_done=0, no done pulse; a following job with k_len=1 completes normally.
REQ-043 Hold start high through a whole job, and pulse calc_done during FEED -> exactly one job per accept; the early calc_done is ignored and completion waits for calc_done in WAIT.
REQ-044 Connect the block to the NDP unit with buffers loaded from the existing 4x5 by 5x4 test vectors, k_len=5 -> result matches the expected A@B vector for every test.
